// File: rtl/zigzag_rle_encoder_if.sv
// Coefficient-in / symbol-out link of the zigzag RLE encoder.
// master is the encoder side (sinks coefficients, sources symbols); slave is its environment.
interface zigzag_rle_encoder_if #(
    parameter int COEF_W = 32
);
    logic              coef_valid;
    logic              coef_ready;
    logic [COEF_W-1:0] coef_data;
    logic              sym_valid;
    logic              sym_ready;
    logic [3:0]        sym_run;
    logic [3:0]        sym_size;
    logic [11:0]       sym_amp;
    logic              sym_dc;
    logic              sym_last;

    modport master (
        input  coef_valid, coef_data, sym_ready,
        output coef_ready, sym_valid, sym_run, sym_size, sym_amp, sym_dc, sym_last
    );

    modport slave (
        output coef_valid, coef_data, sym_ready,
        input  coef_ready, sym_valid, sym_run, sym_size, sym_amp, sym_dc, sym_last
    );
endinterface

// File: rtl/zigzag_rle_encoder.sv
// Buffers one quantized 8x8 MCU in raster order, then emits DC-differential,
// AC run/size/amplitude, ZRL and EOB symbols in zigzag order through one output register.
module zigzag_rle_encoder #(
    parameter int COEF_W    = 32,
    parameter int FRAC_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dc_clear,
    zigzag_rle_encoder_if.master bus
);
    localparam logic [1:0] ST_FILL = 2'd0;
    localparam logic [1:0] ST_DC   = 2'd1;
    localparam logic [1:0] ST_AC   = 2'd2;

    // Raster index of each zigzag position.
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    localparam logic signed [COEF_W-1:0] COEF_MAX = COEF_W'(32'sd2047);
    localparam logic signed [COEF_W-1:0] COEF_MIN = COEF_W'(-32'sd2047);

    function automatic logic signed [11:0] sat_coef(input logic signed [COEF_W-1:0] x);
        logic signed [COEF_W-1:0] v;
        v = x >>> FRAC_BITS;
        if (v > COEF_MAX)
            sat_coef = 12'sd2047;
        else if (v < COEF_MIN)
            sat_coef = -12'sd2047;
        else
            sat_coef = v[11:0];
    endfunction

    function automatic logic signed [11:0] sat_diff(input logic signed [11:0] a,
                                                    input logic signed [11:0] b);
        logic signed [12:0] d;
        d = $signed({a[11], a}) - $signed({b[11], b});
        if (d > 13'sd2047)
            sat_diff = 12'sd2047;
        else if (d < -13'sd2047)
            sat_diff = -12'sd2047;
        else
            sat_diff = d[11:0];
    endfunction

    function automatic logic [3:0] size_cat(input logic signed [11:0] x);
        logic [11:0] mag;
        mag = x[11] ? -x : x;
        size_cat = 4'd0;
        for (int i = 0; i < 11; i++)
            if (mag[i])
                size_cat = 4'(i + 1);
    endfunction

    logic signed [11:0] coef_buf_r [64];
    logic [1:0]         state_r;
    logic [5:0]         cnt_r;
    logic [5:0]         k_r;
    logic [5:0]         run_r;
    logic signed [11:0] dc_pred_r;
    logic               coef_ready_r;
    logic               sym_valid_r;
    logic [3:0]         sym_run_r;
    logic [3:0]         sym_size_r;
    logic [11:0]        sym_amp_r;
    logic               sym_dc_r;
    logic               sym_last_r;

    logic               accept_s;
    logic               out_take_s;
    logic               advance_s;
    logic signed [11:0] coef_int_s;
    logic signed [11:0] cur_s;
    logic signed [11:0] dc_diff_s;

    // Handshake qualifiers and datapath values for the current cycle.
    always_comb begin
        accept_s   = bus.coef_valid && coef_ready_r;
        out_take_s = sym_valid_r && bus.sym_ready;
        advance_s  = !sym_valid_r || bus.sym_ready;
        coef_int_s = sat_coef(bus.coef_data);
        cur_s      = coef_buf_r[ZZ[k_r]];
        // A clear landing on beat 63 already applies to the symbol being built.
        dc_diff_s  = sat_diff(coef_buf_r[0], dc_clear ? 12'sd0 : dc_pred_r);
    end

    // Coefficient buffer write; contents are don't-care until refilled.
    always_ff @(posedge clk) begin
        if (accept_s)
            coef_buf_r[cnt_r] <= coef_int_s;
    end

    // Sequencer and output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_FILL;
            cnt_r        <= 6'd0;
            k_r          <= 6'd0;
            run_r        <= 6'd0;
            dc_pred_r    <= 12'sd0;
            coef_ready_r <= 1'b1;
            sym_valid_r  <= 1'b0;
            sym_run_r    <= 4'd0;
            sym_size_r   <= 4'd0;
            sym_amp_r    <= 12'd0;
            sym_dc_r     <= 1'b0;
            sym_last_r   <= 1'b0;
        end else begin
            if (out_take_s) begin
                sym_valid_r <= 1'b0;
                if (sym_last_r)
                    coef_ready_r <= 1'b1;
            end
            case (state_r)
                ST_FILL: begin
                    if (accept_s) begin
                        cnt_r <= cnt_r + 6'd1;
                        if (cnt_r == 6'd63) begin
                            coef_ready_r <= 1'b0;
                            sym_valid_r  <= 1'b1;
                            sym_run_r    <= 4'd0;
                            sym_size_r   <= size_cat(dc_diff_s);
                            sym_amp_r    <= dc_diff_s;
                            sym_dc_r     <= 1'b1;
                            sym_last_r   <= 1'b0;
                            state_r      <= ST_DC;
                        end
                    end
                end
                ST_DC: begin
                    if (out_take_s) begin
                        dc_pred_r <= coef_buf_r[0];
                        k_r       <= 6'd1;
                        run_r     <= 6'd0;
                        state_r   <= ST_AC;
                    end
                end
                ST_AC: begin
                    if (advance_s) begin
                        if (cur_s == 12'sd0) begin
                            if (k_r != 6'd63) begin
                                run_r <= run_r + 6'd1;
                                k_r   <= k_r + 6'd1;
                            end else begin
                                sym_valid_r <= 1'b1;
                                sym_run_r   <= 4'd0;
                                sym_size_r  <= 4'd0;
                                sym_amp_r   <= 12'd0;
                                sym_dc_r    <= 1'b0;
                                sym_last_r  <= 1'b1;
                                k_r         <= 6'd0;
                                run_r       <= 6'd0;
                                state_r     <= ST_FILL;
                            end
                        end else if (run_r >= 6'd16) begin
                            // Run too long for one symbol: emit ZRL and re-examine this position.
                            sym_valid_r <= 1'b1;
                            sym_run_r   <= 4'd15;
                            sym_size_r  <= 4'd0;
                            sym_amp_r   <= 12'd0;
                            sym_dc_r    <= 1'b0;
                            sym_last_r  <= 1'b0;
                            run_r       <= run_r - 6'd16;
                        end else begin
                            sym_valid_r <= 1'b1;
                            sym_run_r   <= run_r[3:0];
                            sym_size_r  <= size_cat(cur_s);
                            sym_amp_r   <= cur_s;
                            sym_dc_r    <= 1'b0;
                            sym_last_r  <= (k_r == 6'd63);
                            run_r       <= 6'd0;
                            if (k_r == 6'd63) begin
                                k_r     <= 6'd0;
                                state_r <= ST_FILL;
                            end else begin
                                k_r <= k_r + 6'd1;
                            end
                        end
                    end
                end
                default: state_r <= ST_FILL;
            endcase
            if (dc_clear)
                dc_pred_r <= 12'sd0;
        end
    end

    assign bus.coef_ready = coef_ready_r;
    assign bus.sym_valid  = sym_valid_r;
    assign bus.sym_run    = sym_run_r;
    assign bus.sym_size   = sym_size_r;
    assign bus.sym_amp    = sym_amp_r;
    assign bus.sym_dc     = sym_dc_r;
    assign bus.sym_last   = sym_last_r;
endmodule

// File: tb/tb_zigzag_rle_encoder.sv
// Directed and randomized bench for zigzag_rle_encoder against a JPEG-rule reference model.
module tb_zigzag_rle_encoder;
    localparam int COEF_W = 32;

    typedef struct packed {
        logic [3:0]  run;
        logic [3:0]  size;
        logic [11:0] amp;
        logic        dc;
        logic        last;
    } sym_t;

    logic clk = 1'b0;
    logic reset;
    logic dc_clear;

    zigzag_rle_encoder_if #(.COEF_W(COEF_W)) bus ();

    zigzag_rle_encoder #(.COEF_W(COEF_W), .FRAC_BITS(8)) dut (
        .clk(clk), .reset(reset), .dc_clear(dc_clear), .bus(bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          zz [64];
    int          model_pred = 0;
    logic [31:0] raster [64];
    sym_t        exp_q [$];
    sym_t        rx_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int clip(input int x);
        return (x > 2047) ? 2047 : ((x < -2047) ? -2047 : x);
    endfunction

    function automatic int category(input int x);
        int a = (x < 0) ? -x : x;
        int s = 0;
        while ((1 << s) <= a) s++;
        return s;
    endfunction

    function automatic sym_t mk(input int run, input int amp, input bit dc);
        sym_t t;
        t.run = 4'(run); t.size = 4'(category(amp)); t.amp = 12'(amp);
        t.dc = dc; t.last = 1'b0;
        return t;
    endfunction

    // Zigzag order: walk anti-diagonals, alternating direction.
    task automatic build_zigzag();
        int n = 0;
        for (int s = 0; s < 15; s++)
            for (int t = 0; t <= s; t++) begin
                int row = (s % 2 == 1) ? t : s - t;
                int col = s - row;
                if (row < 8 && col < 8) begin zz[n] = row * 8 + col; n++; end
            end
    endtask

    task automatic build_expected();
        int   v [64];
        int   run = 0;
        sym_t t;
        for (int i = 0; i < 64; i++) begin
            logic signed [31:0] x = raster[i];
            v[i] = clip(int'(x >>> 8));
        end
        exp_q.delete();
        exp_q.push_back(mk(0, clip(v[0] - model_pred), 1'b1));
        model_pred = v[0];
        for (int k = 1; k < 64; k++) begin
            if (v[zz[k]] == 0) run++;
            else begin
                while (run >= 16) begin exp_q.push_back(mk(15, 0, 1'b0)); run -= 16; end
                exp_q.push_back(mk(run, v[zz[k]], 1'b0));
                run = 0;
            end
        end
        if (run > 0) exp_q.push_back(mk(0, 0, 1'b0));
        t = exp_q.pop_back(); t.last = 1'b1; exp_q.push_back(t);
    endtask

    task automatic fill_mcu(input int gap_pct);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if ($urandom_range(99) < gap_pct) begin bus.coef_valid = 1'b0; @(negedge clk); end
            check("coef_ready_fill", 32'(bus.coef_ready), 32'd1);
            bus.coef_valid = 1'b1;
            bus.coef_data  = raster[i];
            @(posedge clk);
            #1 bus.coef_valid = 1'b0;
        end
    endtask

    task automatic emit_check(input int ready_pct);
        int   n_exp = exp_q.size();
        int   guard = 0;
        bit   done  = 1'b0;
        bit   held  = 1'b0;
        sym_t cur, hold, e;
        rx_q.delete();
        while (!done && guard < 3000) begin
            @(negedge clk);
            cur = {bus.sym_run, bus.sym_size, bus.sym_amp, bus.sym_dc, bus.sym_last};
            if (guard == 0) check("dc_latency", {30'd0, bus.sym_valid, bus.sym_dc}, 32'd3);
            guard++;
            bus.sym_ready = ($urandom_range(99) < ready_pct);
            check("coef_ready_busy", 32'(bus.coef_ready), 32'd0);
            if (held) begin
                check("hold_valid", 32'(bus.sym_valid), 32'd1);
                check("hold_fields", 32'(cur), 32'(hold));
            end
            held = bus.sym_valid && !bus.sym_ready;
            hold = cur;
            if (bus.sym_valid && bus.sym_ready) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("symbol", 32'(cur), 32'(e));
                end else begin
                    check("extra_symbol", rx_q.size() + 1, n_exp);
                end
                rx_q.push_back(cur);
                if (cur.last) done = 1'b1;
            end
        end
        check("emit_done", 32'(done), 32'd1);
        check("sym_count", rx_q.size(), n_exp);
        @(negedge clk);
        check("coef_ready_after_last", 32'(bus.coef_ready), 32'd1);
        check("idle_valid", 32'(bus.sym_valid), 32'd0);
        bus.sym_ready = 1'b1;
    endtask

    task automatic run_mcu(input int gap_pct, input int ready_pct);
        build_expected();
        fill_mcu(gap_pct);
        emit_check(ready_pct);
    endtask

    task automatic pulse_clear();
        @(negedge clk); dc_clear = 1'b1;
        @(posedge clk); #1 dc_clear = 1'b0;
        model_pred = 0;
    endtask

    task automatic clear_raster();
        for (int i = 0; i < 64; i++) raster[i] = 32'd0;
    endtask

    initial begin
        reset = 1'b1; dc_clear = 1'b0;
        bus.coef_valid = 1'b0; bus.coef_data = 32'd0; bus.sym_ready = 1'b1;
        build_zigzag();
        repeat (2) @(negedge clk);
        check("rst_sym_valid", 32'(bus.sym_valid), 32'd0);
        check("rst_fields", {10'd0, bus.sym_run, bus.sym_size, bus.sym_amp, bus.sym_dc, bus.sym_last}, 32'd0);
        check("rst_coef_ready", 32'(bus.coef_ready), 32'd1);
        reset = 1'b0;

        // Basic MCU
        clear_raster(); raster[0] = 32'h0000_0A00; raster[1] = 32'hFFFF_FD00;
        run_mcu(0, 100);
        check("basic_n", rx_q.size(), 3);
        check("basic_dc", 32'(rx_q[0]), 32'({4'd0, 4'd4, 12'd10, 1'b1, 1'b0}));
        check("basic_ac", 32'(rx_q[1]), 32'({4'd0, 4'd2, 12'hFFD, 1'b0, 1'b0}));
        check("basic_eob", 32'(rx_q[2]), 32'({4'd0, 4'd0, 12'd0, 1'b0, 1'b1}));

        // ZRL split on the last zigzag position
        pulse_clear();
        clear_raster(); raster[63] = 32'h0000_0500;
        run_mcu(10, 100);
        check("zrl_n", rx_q.size(), 5);
        check("zrl_zrl", 32'(rx_q[2]), 32'({4'd15, 4'd0, 12'd0, 1'b0, 1'b0}));
        check("zrl_tail", 32'(rx_q[4]), 32'({4'd14, 4'd3, 12'd5, 1'b0, 1'b1}));

        // DC differential and predictor clear
        clear_raster(); raster[0] = 32'h0000_1400; run_mcu(0, 100);
        check("dc_20", 32'(rx_q[0].amp), 32'd20);
        clear_raster(); raster[0] = 32'h0000_0F00; run_mcu(0, 100);
        check("dc_m5", 32'(rx_q[0].amp), 32'hFFB);
        pulse_clear();
        clear_raster(); raster[0] = 32'h0000_0F00; run_mcu(0, 100);
        check("dc_15", 32'(rx_q[0].amp), 32'd15);

        // Saturation
        pulse_clear();
        clear_raster(); raster[0] = 32'h7FFF_FF00; run_mcu(0, 100);
        check("sat_pos", 32'({rx_q[0].size, rx_q[0].amp}), 32'({4'd11, 12'h7FF}));
        clear_raster(); raster[0] = 32'h8000_0000; run_mcu(0, 100);
        check("sat_neg", 32'({rx_q[0].size, rx_q[0].amp}), 32'({4'd11, 12'h801}));

        // Backpressure on the basic MCU
        pulse_clear();
        clear_raster(); raster[0] = 32'h0000_0A00; raster[1] = 32'hFFFF_FD00;
        run_mcu(0, 30);
        check("bp_n", rx_q.size(), 3);

        // Randomized MCUs
        for (int m = 0; m < 8; m++) begin
            int zero_pct = (m % 2 == 0) ? 70 : 96;
            for (int i = 0; i < 64; i++) begin
                int r = $urandom_range(99);
                if (r < zero_pct) raster[i] = 32'd0;
                else if (r < 97) raster[i] = 32'($signed($urandom_range(80)) - 40) << 8 | 32'($urandom_range(255));
                else raster[i] = $urandom;
            end
            if (m == 3) pulse_clear();
            run_mcu(15, (m % 3 == 0) ? 100 : 40);
        end

        // Reset while an AC symbol is pending
        clear_raster(); raster[0] = 32'h0000_0300; raster[1] = 32'h0000_0200; raster[10] = 32'h0000_0100;
        fill_mcu(0);
        @(negedge clk);
        check("rm_dc_valid", {30'd0, bus.sym_valid, bus.sym_dc}, 32'd3);
        bus.sym_ready = 1'b1;
        @(negedge clk); bus.sym_ready = 1'b0;
        @(negedge clk);
        check("rm_ac_pending", {30'd0, bus.sym_valid, bus.sym_dc}, 32'd2);
        reset = 1'b1;
        #1;
        check("rm_valid_drop", 32'(bus.sym_valid), 32'd0);
        @(negedge clk); reset = 1'b0; bus.sym_ready = 1'b1; model_pred = 0;
        @(negedge clk);
        check("rm_coef_ready", 32'(bus.coef_ready), 32'd1);
        clear_raster();
        run_mcu(0, 100);
        check("rm_zero_n", rx_q.size(), 2);
        check("rm_zero_dc", 32'(rx_q[0]), 32'({4'd0, 4'd0, 12'd0, 1'b1, 1'b0}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
